// File: rtl/serial_pattern_tx_if.sv
// Request/response bundle between a stimulus source and serial_pattern_tx.
// master drives the request fields; slave (the transmitter) drives the serial output and status.
interface serial_pattern_tx_if #(
    parameter int MAX_LEN   = 16,
    parameter int LEN_W     = 5,
    parameter int DIV_WIDTH = 8
);
    logic                 start;
    logic                 abort;
    logic [MAX_LEN-1:0]   pattern;
    logic [LEN_W-1:0]     length;
    logic [3:0]           repeat_count;
    logic [DIV_WIDTH-1:0] div;
    logic                 w_out;
    logic                 busy;
    logic                 done;
    logic [1:0]           state;

    modport master (
        output start, abort, pattern, length, repeat_count, div,
        input  w_out, busy, done, state
    );

    modport slave (
        input  start, abort, pattern, length, repeat_count, div,
        output w_out, busy, done, state
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a latched pattern out MSB-first, each bit held div+1
// clocks, with optional repeat passes separated by one zero bit period.
module serial_pattern_tx #(
    parameter int MAX_LEN   = 16,
    parameter int LEN_W     = 5,
    parameter int DIV_WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    serial_pattern_tx_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [MAX_LEN-1:0]   pat_q;
    logic [MAX_LEN-1:0]   shreg_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     bit_cnt_q;
    logic [3:0]           rep_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] tick_q;

    logic [LEN_W-1:0]     len_eff;
    logic [LEN_W-1:0]     shamt;
    logic                 start_ok;
    logic                 tick_hit;
    logic                 bit_last;

    assign len_eff  = (bus.length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.length;
    assign shamt    = LEN_W'(MAX_LEN) - len_eff;
    assign start_ok = bus.start && (bus.length != '0);
    assign tick_hit = (tick_q == div_q);
    assign bit_last = (bit_cnt_q == len_q - LEN_W'(1));

    always_ff @(posedge clock) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_ok) state_d = SEND;
            SEND: begin
                if (bus.abort)                state_d = IDLE;
                else if (tick_hit && bit_last) state_d = (rep_q != 4'd0) ? GAP : DONE;
            end
            GAP: begin
                if (bus.abort)    state_d = IDLE;
                else if (tick_hit) state_d = SEND;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: the pattern is stored left-aligned so the next bit is always the MSB.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pat_q     <= '0;
            shreg_q   <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            rep_q     <= '0;
            div_q     <= '0;
            tick_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_ok) begin
                    pat_q     <= bus.pattern;
                    shreg_q   <= bus.pattern << shamt;
                    len_q     <= len_eff;
                    rep_q     <= bus.repeat_count;
                    div_q     <= bus.div;
                    tick_q    <= '0;
                    bit_cnt_q <= '0;
                end
                SEND: begin
                    if (bus.abort) begin
                        tick_q <= '0;
                    end else if (tick_hit) begin
                        tick_q    <= '0;
                        shreg_q   <= shreg_q << 1;
                        bit_cnt_q <= bit_cnt_q + LEN_W'(1);
                    end else begin
                        tick_q <= tick_q + DIV_WIDTH'(1);
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        tick_q <= '0;
                    end else if (tick_hit) begin
                        tick_q    <= '0;
                        shreg_q   <= pat_q << (LEN_W'(MAX_LEN) - len_q);
                        bit_cnt_q <= '0;
                        rep_q     <= rep_q - 4'd1;
                    end else begin
                        tick_q <= tick_q + DIV_WIDTH'(1);
                    end
                end
                default: tick_q <= '0;
            endcase
        end
    end

    always_comb begin
        bus.w_out = (state_q == SEND) ? shreg_q[MAX_LEN-1] : 1'b0;
        bus.busy  = (state_q == SEND) || (state_q == GAP);
        bus.done  = (state_q == DONE);
        bus.state = state_q;
    end
endmodule
